// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// The optional timeout path is enabled with `define MEM_ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mem_arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_DATA  = 1;
    localparam int unsigned REQ_DBG   = 2;

    // Width of an index into n requesters, never below one bit.
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after `last`, wrapping.
// Reports the winner index and whether any request was set.
module rr_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = idxWidth(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] candIdx;

    always_comb begin
        winner  = '0;
        valid   = 1'b0;
        candIdx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            candIdx = IW'((32'(last) + i) % N);
            if (!valid && req[candIdx]) begin
                valid  = 1'b1;
                winner = candIdx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between NUM_REQ requesters, one transaction in flight.
// Define MEM_ARB_TIMEOUT_EN to add the ISSUE/WAIT timeout error path.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0][31:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0][3:0]   req_be_i,
    input  logic [NUM_REQ-1:0][31:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        resp_valid_o,
    output logic [31:0]               resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      mem_req_o,
    output logic [31:0]               mem_addr_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [31:0]               mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [31:0]               mem_rdata_i
);

    localparam int unsigned IW = idxWidth(NUM_REQ);

    mem_arb_state_t state, stateNext;

    logic [IW-1:0] rrLast;
    logic [IW-1:0] owner;
    logic [IW-1:0] pickIdx;
    logic          pickValid;
    mem_req_t      curReq;
    logic [31:0]   respRdata;
    logic          accept;
    logic          complete;
    logic          timeout;
    logic          errFlag;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req    (req_valid_i),
        .last   (rrLast),
        .winner (pickIdx),
        .valid  (pickValid)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0] timeoutCnt;
    logic        termCycle;

    assign termCycle = (timeoutCnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (pickValid) begin
                    accept    = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    complete  = 1'b1;
                    stateNext = RESP;
                end else if (mem_gnt_i) begin
                    stateNext = WAIT;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // A grant without data on the terminal cycle still times out.
                if (!complete && termCycle) begin
                    timeout   = 1'b1;
                    stateNext = RESP;
                end
`endif
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    complete  = 1'b1;
                    stateNext = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (termCycle) begin
                    timeout   = 1'b1;
                    stateNext = RESP;
                end
`endif
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrLast    <= IW'(NUM_REQ - 1);
            owner     <= IW'(REQ_FETCH);
            curReq    <= '0;
            respRdata <= '0;
            errFlag   <= 1'b0;
        end else begin
            if (accept) begin
                rrLast       <= pickIdx;
                owner        <= pickIdx;
                curReq.addr  <= req_addr_i[pickIdx];
                curReq.we    <= req_we_i[pickIdx];
                curReq.be    <= req_be_i[pickIdx];
                curReq.wdata <= req_wdata_i[pickIdx];
                errFlag      <= 1'b0;
            end
            if (complete) begin
                respRdata <= mem_rdata_i;
                errFlag   <= 1'b0;
            end
            if (timeout) begin
                respRdata <= '0;
                errFlag   <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            timeoutCnt <= '0;
        end else if (state == ISSUE || state == WAIT) begin
            timeoutCnt <= timeoutCnt + 32'd1;
        end
    end

    assign resp_err_o = (state == RESP) && errFlag && !rst;
`else
    logic unusedErrFlag;

    assign unusedErrFlag = errFlag;
    assign resp_err_o    = 1'b0;
`endif

    assign req_ready_o  = (accept && !rst) ? (NUM_REQ'(1) << pickIdx) : '0;
    assign resp_valid_o = (state == RESP && !rst) ? (NUM_REQ'(1) << owner) : '0;
    assign resp_rdata_o = respRdata;
    assign mem_req_o    = (state == ISSUE);
    assign mem_addr_o   = curReq.addr;
    assign mem_we_o     = curReq.we;
    assign mem_be_o     = curReq.be;
    assign mem_wdata_o  = curReq.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses, a monitor pops them.
// Build with MEM_ARB_TIMEOUT_EN to exercise the timeout path.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned NR = 3;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 64;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        reqValid;
    logic [NR-1:0][31:0]  reqAddr;
    logic [NR-1:0]        reqWe;
    logic [NR-1:0][3:0]   reqBe;
    logic [NR-1:0][31:0]  reqWdata;
    logic [NR-1:0]        reqReady;
    logic [NR-1:0]        respValid;
    logic [31:0]          respRdata;
    logic                 respErr;
    logic                 memReq;
    logic [31:0]          memAddr;
    logic                 memWe;
    logic [3:0]           memBe;
    logic [31:0]          memWdata;
    logic                 memGnt;
    logic                 memRvalid;
    logic [31:0]          memRdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (reqValid),
        .req_addr_i   (reqAddr),
        .req_we_i     (reqWe),
        .req_be_i     (reqBe),
        .req_wdata_i  (reqWdata),
        .req_ready_o  (reqReady),
        .resp_valid_o (respValid),
        .resp_rdata_o (respRdata),
        .resp_err_o   (respErr),
        .mem_req_o    (memReq),
        .mem_addr_o   (memAddr),
        .mem_we_o     (memWe),
        .mem_be_o     (memBe),
        .mem_wdata_o  (memWdata),
        .mem_gnt_i    (memGnt),
        .mem_rvalid_i (memRvalid),
        .mem_rdata_i  (memRdata)
    );

    typedef struct {
        int unsigned owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int unsigned r);
        return 32'(1) << r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (respValid !== '0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got valid=%b want none", respValid);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("mon_owner", 32'(respValid), oh(e.owner));
                chk("mon_rdata", respRdata, e.rdata);
                chk("mon_err", 32'(respErr), 32'(e.err));
            end
        end
    end

    // Valid is held through the whole transaction so ready must stay low until IDLE.
    task automatic txn(input int unsigned r, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd, input int unsigned gd,
                       input int unsigned rd, input logic [31:0] rdat);
        cyc();
        reqValid[r] = 1'b1;
        reqAddr[r]  = a;
        reqWe[r]    = we;
        reqBe[r]    = be;
        reqWdata[r] = wd;
        @(negedge clk);
        chk("ready_accept", 32'(reqReady), oh(r));
        expQ.push_back('{r, rdat, 1'b0});
        for (int unsigned k = 0; k <= gd; k++) begin
            cyc();
            if (k == gd) begin
                memGnt = 1'b1;
                if (rd == 0) begin
                    memRvalid = 1'b1;
                    memRdata  = rdat;
                end
            end
            @(negedge clk);
            chk("issue_req", 32'(memReq), 32'd1);
            chk("issue_addr", memAddr, a);
            chk("issue_we", 32'(memWe), 32'(we));
            chk("issue_be", 32'(memBe), 32'(be));
            chk("issue_wdata", memWdata, wd);
            chk("issue_noready", 32'(reqReady), 32'd0);
        end
        cyc();
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        if (rd > 0) begin
            for (int unsigned k = 1; k < rd; k++) begin
                @(negedge clk);
                chk("wait_noreq", 32'(memReq), 32'd0);
                chk("wait_noready", 32'(reqReady), 32'd0);
                cyc();
            end
            memRvalid = 1'b1;
            memRdata  = rdat;
            @(negedge clk);
            chk("wait_noreq", 32'(memReq), 32'd0);
            cyc();
            memRvalid = 1'b0;
        end
        @(negedge clk);
        chk("resp_pulse", 32'(respValid), oh(r));
        chk("resp_noready", 32'(reqReady), 32'd0);
        cyc();
        reqValid[r] = 1'b0;
        @(negedge clk);
        chk("resp_once", 32'(respValid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        reqValid  = '1;
        reqAddr   = '0;
        reqWe     = '0;
        reqBe     = '0;
        reqWdata  = '0;
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        memRdata  = '0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_ready", 32'(reqReady), 32'd0);
        chk("rst_resp_valid", 32'(respValid), 32'd0);
        chk("rst_rdata", respRdata, 32'd0);
        chk("rst_err", 32'(respErr), 32'd0);
        chk("rst_mem_req", 32'(memReq), 32'd0);
        chk("rst_addr", memAddr, 32'd0);
        chk("rst_we", 32'(memWe), 32'd0);
        chk("rst_be", 32'(memBe), 32'd0);
        chk("rst_wdata", memWdata, 32'd0);
        cyc();
        rst      = 1'b0;
        reqValid = '0;

        // Single fetch, gnt+rvalid together right after acceptance.
        txn(REQ_FETCH, 32'h8000_0004, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0000_0013);
        // Store with delayed grant and a separate rvalid.
        txn(REQ_DATA, 32'h8000_1000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 3, 2, 32'hA5A5_0000);
        // Same-cycle gnt+rvalid skips WAIT.
        txn(REQ_DBG, 32'h8000_2000, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1234_5678);

        // Spurious rvalid in IDLE.
        cyc();
        memRvalid = 1'b1;
        memRdata  = 32'h0000_0BAD;
        @(negedge clk);
        chk("spur_noready", 32'(reqReady), 32'd0);
        chk("spur_noreq", 32'(memReq), 32'd0);
        cyc();
        memRvalid = 1'b0;
        @(negedge clk);
        chk("spur_noreq2", 32'(memReq), 32'd0);
        chk("spur_rdata_hold", respRdata, 32'h1234_5678);

        // Reset while in WAIT, then a late rvalid.
        cyc();
        reqValid[REQ_DATA] = 1'b1;
        reqAddr[REQ_DATA]  = 32'h8000_3000;
        @(negedge clk);
        chk("rstw_ready", 32'(reqReady), oh(REQ_DATA));
        cyc();
        reqValid[REQ_DATA] = 1'b0;
        memGnt = 1'b1;
        @(negedge clk);
        chk("rstw_issue", 32'(memReq), 32'd1);
        cyc();
        memGnt = 1'b0;
        @(negedge clk);
        chk("rstw_wait", 32'(memReq), 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_noresp", 32'(respValid), 32'd0);
        cyc();
        rst       = 1'b0;
        memRvalid = 1'b1;
        memRdata  = 32'h0000_BAD1;
        @(negedge clk);
        chk("rstw_late_noreq", 32'(memReq), 32'd0);
        cyc();
        memRvalid = 1'b0;
        @(negedge clk);
        chk("rstw_rdata_clr", respRdata, 32'd0);
        cyc();
        reqValid = '1;
        reqAddr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        @(negedge clk);
        chk("rstw_next_grant", 32'(reqReady), oh(REQ_FETCH));
        expQ.push_back('{REQ_FETCH, 32'h0000_0055, 1'b0});
        cyc();
        reqValid  = '0;
        memGnt    = 1'b1;
        memRvalid = 1'b1;
        memRdata  = 32'h0000_0055;
        @(negedge clk);
        chk("rstw_next_addr", memAddr, 32'h0000_1000);
        cyc();
        memGnt    = 1'b0;
        memRvalid = 1'b0;
        @(negedge clk);
        chk("rstw_next_resp", 32'(respValid), oh(REQ_FETCH));
        cyc();

        // Fairness with all requesters continuously valid from a fresh reset.
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        reqValid = '1;
        for (int unsigned n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rr_grant", 32'(reqReady), oh(n % 3));
            expQ.push_back('{n % 3, 32'h100 + n, 1'b0});
            cyc();
            memGnt    = 1'b1;
            memRvalid = 1'b1;
            memRdata  = 32'h100 + n;
            @(negedge clk);
            chk("rr_addr", memAddr, 32'h1000 * ((n % 3) + 1));
            chk("rr_noready_issue", 32'(reqReady), 32'd0);
            cyc();
            memGnt    = 1'b0;
            memRvalid = 1'b0;
            @(negedge clk);
            chk("rr_resp", 32'(respValid), oh(n % 3));
            chk("rr_noready_resp", 32'(reqReady), 32'd0);
            cyc();
        end
        reqValid = '0;

        // Grant without rvalid: timeout error, or indefinite wait without the feature.
        cyc();
        reqValid[REQ_DBG] = 1'b1;
        reqAddr[REQ_DBG]  = 32'h8000_4000;
        @(negedge clk);
        chk("to_ready", 32'(reqReady), oh(REQ_DBG));
        cyc();
        reqValid = '0;
        memGnt   = 1'b1;
        @(negedge clk);
        chk("to_issue", 32'(memReq), 32'd1);
        cyc();
        memGnt = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        expQ.push_back('{REQ_DBG, 32'h0, 1'b1});
        for (int unsigned k = 1; k < TO; k++) begin
            @(negedge clk);
            chk("to_waiting", 32'(respValid), 32'd0);
            cyc();
        end
        @(negedge clk);
        chk("to_resp", 32'(respValid), oh(REQ_DBG));
        chk("to_err", 32'(respErr), 32'd1);
        chk("to_rdata", respRdata, 32'd0);
        cyc();
        memRvalid = 1'b1;
        memRdata  = 32'h0000_DEAD;
        @(negedge clk);
        chk("to_stray_noresp", 32'(respValid), 32'd0);
        cyc();
        memRvalid = 1'b0;
`else
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("nto_waiting", 32'(respValid), 32'd0);
            chk("nto_noreq", 32'(memReq), 32'd0);
            cyc();
        end
        expQ.push_back('{REQ_DBG, 32'h0000_C0DE, 1'b0});
        memRvalid = 1'b1;
        memRdata  = 32'h0000_C0DE;
        @(negedge clk);
        cyc();
        memRvalid = 1'b0;
        @(negedge clk);
        chk("nto_resp", 32'(respValid), oh(REQ_DBG));
        chk("nto_err", 32'(respErr), 32'd0);
        cyc();
`endif

        repeat (3) cyc();
        chk("queue_empty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between NUM_REQ core-side requesters: instruction fetch, data load/store and the debug loader.
- Uses round-robin arbitration, a valid/ready handshake toward the requesters and a req/gnt/rvalid handshake toward memory.
- Allows exactly one transaction in flight.
- Sits between the core's pc/data memory interface and the SoC memory.
- The core stalls on the missing ready/resp signals.

Parameters:
- NUM_REQ, 3, number of requesters. Index 0 = fetch, 1 = data, 2 = debug.
- TIMEOUT_CYCLES, 64, cycles spent in ISSUE+WAIT before a timeout error. Used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_addr_i  in  NUM_REQ x 32  byte address
- req_we_i  in  NUM_REQ  1 = store
- req_be_i  in  NUM_REQ x 4  byte enables
- req_wdata_i  in  NUM_REQ x 32  store data
- req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- resp_valid_o  out  NUM_REQ  one-cycle response pulse to the owner
- resp_rdata_o  out  32  response data, shared by all requesters
- resp_err_o  out  1  timeout error, qualified by resp_valid_o
- mem_req_o  out  1  memory request
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  32/1/4/32  latched request fields
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data

Behaviour:
- Reset:
  - state=IDLE, rr_last=NUM_REQ-1.
  - All outputs 0: req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_req_o, mem_addr/we/be/wdata.
- IDLE:
  - If any req_valid_i is set, pick the winner round-robin, searching from rr_last+1 upward with wrap-around.
  - Same cycle: assert req_ready_o[winner] combinationally, latch addr/we/be/wdata, record owner, set rr_last=winner, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - mem_req_o=1 with the latched fields, held stable until mem_gnt_i.
  - On mem_gnt_i, go to WAIT.
  - If mem_rvalid_i arrives in the same cycle as mem_gnt_i, capture it and go directly to RESP.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, capture mem_rdata_i into resp_rdata_o and go to RESP.
- RESP:
  - resp_valid_o[owner]=1 for exactly one cycle, then go to IDLE.
  - A new grant is not made in RESP. Minimum occupancy is 3 cycles per transaction: accept, issue+gnt+rvalid, resp.
- Stores also receive a resp_valid_o pulse as the write acknowledge. resp_rdata_o holds whatever the memory returned.
- resp_rdata_o holds its value until the next capture. req_ready_o is never asserted outside IDLE.
- Requesters must hold valid and fields until ready. A request whose valid drops before it is accepted is simply never served.
- mem_rvalid_i in IDLE, ISSUE-without-gnt or RESP is spurious: ignored, no state change.
- Reset mid-transaction: return to IDLE immediately and drop mem_req_o. A late rvalid is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… No requester waits more than NUM_REQ-1 transactions.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entering ISSUE and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: drop mem_req_o, go to RESP with resp_err_o=1 and resp_rdata_o=0.
  - A later stray rvalid is ignored.
  - Completion on the exact terminal cycle counts as success.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter. resp_err_o is tied to 0.
  - The block waits indefinitely in ISSUE/WAIT.

Decomposition:
- Common package:
  - mem_arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - mem_req_t struct {addr, we, be, wdata}
  - constants REQ_FETCH=0, REQ_DATA=1, REQ_DBG=2
- Sub-module rr_arbiter: a combinational pick of the winner index plus a valid flag, from the req vector and rr_last. It is instantiated once.

Test Plan:
- Single fetch: valid[0] with addr 0x8000_0004, gnt and rvalid the cycle after ready, rdata 0x0000_0013 -> ready[0] at cycle 0, mem_req_o at cycle 1 with addr 0x8000_0004, resp_valid[0] at cycle 2 with rdata 0x13, one pulse only.
- Store ack: valid[1], we=1, be=4'b0011, addr 0x8000_1000, wdata 0xDEAD_BEEF, gnt delayed 3 cycles -> mem_req_o and fields held stable 4 cycles, resp_valid[1] after rvalid, ready never re-asserted meanwhile.
- Fairness: all three valid continuously for 6 transactions -> grant order 0,1,2,0,1,2, one outstanding at a time.
- Spurious/reset: rvalid in IDLE -> no resp. Reset asserted in WAIT, then rvalid -> no resp_valid, mem_req_o=0, next grant goes to requester 0.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): gnt given, rvalid never -> resp_valid[owner] with resp_err_o=1 and rdata 0 eight cycles after ISSUE entry. Without the macro, the block remains in WAIT.
- Same-cycle gnt+rvalid with rdata 0x1234_5678 -> resp_valid on the next cycle with rdata 0x1234_5678, WAIT skipped.
